matmul_ctrl_part4: RTL and testbench
====================================

Name: matmul_ctrl_part4

Overview:
- Sequencer that drives the part-4 matrix-vector datapath (datapath_part4). It streams in one X vector (8 words) and, optionally, one W matrix (64 words), then steps the datapath through 8 row dot-products.
- Each row result is returned on a valid/ready output stream.
- Sits between the top-level stream interfaces and the datapath. It is the initiator side of the datapath's load/compute control interface.

Parameters:
- DATA_W, 14, input element width; must match datapath.
- ACC_W, 28, result width; must match datapath.
- N, 8, vector length and row count; fixed at 8 (datapath is hard-wired).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  start request
- cmd_ready  out  1  high only in IDLE
- cmd_skip_w  in  1  sampled with cmd: reuse resident W, load X only
- in_valid  in  1  input word valid
- in_ready  out  1  high only in LOAD_X / LOAD_W
- in_data  in  DATA_W  signed input word
- out_valid  out  1  row result valid
- out_ready  in  1  downstream accept
- out_data  out  ACC_W  signed row result
- out_last  out  1  high with row 7 result
- busy  out  1  state != IDLE
- dp_input_data  out  DATA_W  = in_data (combinational)
- dp_addr_x  out  3  X write index
- dp_wr_en_x  out  1  X write strobe
- dp_addr_w  out  6  W address, {row, col}
- dp_wr_en_w  out  1  W write strobe
- dp_clear_acc  out  1  datapath accumulator clear
- dp_en_acc  out  1  datapath accumulator capture
- dp_en_pipe  out  1  datapath pipeline enable
- dp_output_data  in  ACC_W  datapath result

Behaviour:
- Reset (async, any state): state=IDLE, counters=0, w_loaded=0. All outputs 0 except cmd_ready=1. Datapath memory contents are not touched.
- Datapath timing is decided as follows:
  - Memory writes occur at the posedge with the strobe.
  - Reads are combinational on the address.
  - Results are 2 en_pipe stages, then 1 en_acc register.
- States: IDLE, LOAD_X, LOAD_W, ISSUE, FLUSH, CAPTURE, OUTPUT.
- IDLE:
  - cmd_valid&cmd_ready accepted → dp_clear_acc=1 for that cycle, x_cnt=0.
  - Next state is LOAD_X.
  - Effective skip = cmd_skip_w & w_loaded. If w_loaded=0, the W load is forced regardless of cmd_skip_w.
- LOAD_X:
  - Per in handshake: dp_wr_en_x=1, dp_addr_x=x_cnt, x_cnt++.
  - After 8th word: go to LOAD_W (w_cnt=0) if not skip, else ISSUE (row=0).
- LOAD_W:
  - Per handshake: dp_wr_en_w=1, dp_addr_w=w_cnt, w_cnt++.
  - Word k is W[k>>3][k&7], row-major.
  - After 64th word: w_loaded=1, row=0, go to ISSUE.
- Strobes are combinational on handshake (in_valid&in_ready). No write without handshake. in_valid outside load states is ignored.
- ISSUE: dp_addr_w={row,3'b000}, dp_en_pipe=1 → FLUSH.
- FLUSH: dp_addr_w unchanged, dp_en_pipe=1 → CAPTURE.
- CAPTURE: dp_en_acc=1 → OUTPUT.
- OUTPUT:
  - out_valid=1, out_data=dp_output_data, out_last=(row==7).
  - Holds stable until out_ready.
  - On accept: row==7 → IDLE; else row++ → ISSUE.
- Latency: out_valid rises 3 cycles after ISSUE entry. Minimum 4 cycles per row with out_ready tied high.
- Pipeline stalls under backpressure are not needed: dp_en_pipe/dp_en_acc are 0 in OUTPUT, so the datapath state is frozen.
- Counters: x_cnt 3b, w_cnt 6b, row 3b. Wrap after the final element is the terminal condition, not an error.
- Arithmetic is done in the datapath. The controller never modifies data widths or values.
- Reset mid-load: partially written W is left resident, but w_loaded=0, so the next cmd forces a full W reload.

Test Plan:
- Load X=[1..8], W=identity, out_ready=1 → 8 results 1,2,...,8. out_last only on the 8th. First out_valid 3 cycles after last W handshake+1.
- Second cmd with cmd_skip_w=1, X=[2]*8 → exactly 8 input handshakes; results all 2; no dp_wr_en_w pulses.
- After reset, cmd_skip_w=1 → 72 input words still required (forced W load); W all 1, X=[1..8] → all results 36.
- Hold out_ready=0 for 5 cycles at row 3 → out_data/out_valid stable; dp_en_pipe=dp_en_acc=0; row 3 result correct on release.
- in_valid toggling 1-0-1 during LOAD_W → writes only on handshake cycles, dp_addr_w sequential 0..63 without skips.
- Assert rst mid-OUTPUT at row 5 → outputs 0 asynchronously, cmd_ready=1, busy=0 on the same edge.

Source files
------------

// File: rtl/matmul_ctrl_part4.sv
// -----------------------------------------------------------------------------
// matmul_ctrl_part4
//
// Sequencer for the part-4 matrix-vector datapath. A command loads one X
// vector (8 words) and, unless a resident W may be reused, one W matrix
// (64 words, row-major). It then steps the datapath through the 8 row
// dot-products and returns each row result on a valid/ready output stream.
//
// Handshake semantics (all three streams): a transfer happens on a rising
// clk edge where valid and ready are both high. A producer holds valid and
// its payload stable until that transfer. ready may depend on state only,
// never on the partner's valid.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cmd_valid/ready start request; cmd_ready is high only in IDLE
//   cmd_skip_w      sampled with the command: reuse resident W (if loaded)
//   in_valid/ready  input word stream; in_ready high only while loading
//   in_data         signed input word, forwarded to dp_input_data
//   out_valid/ready row result stream
//   out_data        signed row result (datapath result during OUTPUT)
//   out_last        marks the row 7 result
//   busy            controller is not idle
//   dp_*            initiator side of the datapath load/compute interface
// -----------------------------------------------------------------------------
module matmul_ctrl_part4 #(
  parameter int DATA_W = 14,
  parameter int ACC_W  = 28,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_skip_w,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic [DATA_W-1:0] dp_input_data,
  output logic [2:0]        dp_addr_x,
  output logic              dp_wr_en_x,
  output logic [5:0]        dp_addr_w,
  output logic              dp_wr_en_w,
  output logic              dp_clear_acc,
  output logic              dp_en_acc,
  output logic              dp_en_pipe,
  input  logic [ACC_W-1:0]  dp_output_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_X  = 3'd1,
    S_LOAD_W  = 3'd2,
    S_ISSUE   = 3'd3,
    S_FLUSH   = 3'd4,
    S_CAPTURE = 3'd5,
    S_OUTPUT  = 3'd6
  } state_t;

  // Registered state and counters
  state_t     state;
  logic [2:0] x_cnt;
  logic [5:0] w_cnt;
  logic [2:0] row;
  logic       w_loaded;
  logic       skip_r;

  // Next-state values
  state_t     state_nx;
  logic [2:0] x_nx;
  logic [5:0] w_nx;
  logic [2:0] row_nx;
  logic       wl_nx;
  logic       skip_nx;

  logic       cmd_fire;
  logic       in_fire;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign in_fire  = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    x_nx     = x_cnt;
    w_nx     = w_cnt;
    row_nx   = row;
    wl_nx    = w_loaded;
    skip_nx  = skip_r;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          x_nx     = 3'd0;
          // Skipping is only honoured when a complete W is resident.
          skip_nx  = cmd_skip_w & w_loaded;
          state_nx = S_LOAD_X;
        end
      end
      S_LOAD_X: begin
        if (in_fire) begin
          x_nx = 3'(x_cnt + 3'd1);
          if (x_cnt == 3'd7) begin
            if (skip_r) begin
              row_nx   = 3'd0;
              state_nx = S_ISSUE;
            end else begin
              w_nx     = 6'd0;
              // W is about to be overwritten; it is not valid until the
              // 64th word lands.
              wl_nx    = 1'b0;
              state_nx = S_LOAD_W;
            end
          end
        end
      end
      S_LOAD_W: begin
        if (in_fire) begin
          w_nx = 6'(w_cnt + 6'd1);
          if (w_cnt == 6'd63) begin
            wl_nx    = 1'b1;
            row_nx   = 3'd0;
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE:   state_nx = S_FLUSH;
      S_FLUSH:   state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_OUTPUT;
      S_OUTPUT: begin
        if (out_ready) begin
          if (row == 3'd7) begin
            state_nx = S_IDLE;
          end else begin
            row_nx   = 3'(row + 3'd1);
            state_nx = S_ISSUE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM register. State-decoded outputs are registered from the next state so
  // they change cleanly with the state itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      x_cnt      <= 3'd0;
      w_cnt      <= 6'd0;
      row        <= 3'd0;
      w_loaded   <= 1'b0;
      skip_r     <= 1'b0;
      cmd_ready  <= 1'b1;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      dp_en_pipe <= 1'b0;
      dp_en_acc  <= 1'b0;
    end else begin
      state      <= state_nx;
      x_cnt      <= x_nx;
      w_cnt      <= w_nx;
      row        <= row_nx;
      w_loaded   <= wl_nx;
      skip_r     <= skip_nx;
      cmd_ready  <= (state_nx == S_IDLE);
      in_ready   <= (state_nx == S_LOAD_X) || (state_nx == S_LOAD_W);
      busy       <= (state_nx != S_IDLE);
      out_valid  <= (state_nx == S_OUTPUT);
      out_last   <= (state_nx == S_OUTPUT) && (row_nx == 3'd7);
      dp_en_pipe <= (state_nx == S_ISSUE) || (state_nx == S_FLUSH);
      dp_en_acc  <= (state_nx == S_CAPTURE);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath-facing combinational outputs
  // ---------------------------------------------------------------------------
  assign dp_input_data = in_data;
  assign dp_addr_x     = x_cnt;
  assign dp_wr_en_x    = in_fire && (state == S_LOAD_X);
  assign dp_wr_en_w    = in_fire && (state == S_LOAD_W);
  assign dp_clear_acc  = cmd_fire;

  // During compute the W read address points at the start of the current row;
  // the datapath reads the whole row combinationally from that base.
  always_comb begin
    dp_addr_w = 6'd0;
    case (state)
      S_LOAD_W:                                  dp_addr_w = w_cnt;
      S_ISSUE, S_FLUSH, S_CAPTURE, S_OUTPUT:     dp_addr_w = {row, 3'b000};
      default:                                   dp_addr_w = 6'd0;
    endcase
  end

  // The datapath is frozen in OUTPUT (no en_pipe/en_acc), so its result is
  // stable for as long as backpressure lasts.
  assign out_data = out_valid ? dp_output_data : '0;

endmodule

// File: tb/tb_matmul_ctrl_part4.sv
module tb_matmul_ctrl_part4;

  localparam int DATA_W = 14;
  localparam int ACC_W  = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_skip_w;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready, out_last, busy;
  logic [ACC_W-1:0]  out_data;
  logic [DATA_W-1:0] dp_input_data;
  logic [2:0]        dp_addr_x;
  logic              dp_wr_en_x;
  logic [5:0]        dp_addr_w;
  logic              dp_wr_en_w;
  logic              dp_clear_acc, dp_en_acc, dp_en_pipe;
  logic [ACC_W-1:0]  dp_output_data;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  matmul_ctrl_part4 #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_skip_w     (cmd_skip_w),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .dp_input_data  (dp_input_data),
    .dp_addr_x      (dp_addr_x),
    .dp_wr_en_x     (dp_wr_en_x),
    .dp_addr_w      (dp_addr_w),
    .dp_wr_en_w     (dp_wr_en_w),
    .dp_clear_acc   (dp_clear_acc),
    .dp_en_acc      (dp_en_acc),
    .dp_en_pipe     (dp_en_pipe),
    .dp_output_data (dp_output_data)
  );

  // ---------------------------------------------------------------------------
  // Behavioural datapath: X/W memories written on strobe, combinational row
  // read, two pipe stages, one accumulator register.
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] xm [8];
  logic signed [DATA_W-1:0] wm [64];
  logic signed [ACC_W-1:0]  s1, s2, acc;

  function automatic logic signed [ACC_W-1:0] row_dot(input logic [2:0] r);
    int s;
    s = 0;
    for (int c = 0; c < 8; c++) begin
      s += int'(xm[c]) * int'(wm[{r, 3'(c)}]);
    end
    return ACC_W'(s);
  endfunction

  always @(posedge clk) begin
    if (dp_wr_en_x) xm[dp_addr_x] <= dp_input_data;
    if (dp_wr_en_w) wm[dp_addr_w] <= dp_input_data;
    if (dp_en_pipe) begin
      s1 <= row_dot(dp_addr_w[5:3]);
      s2 <= s1;
    end
    if (dp_clear_acc)   acc <= '0;
    else if (dp_en_acc) acc <= s2;
  end

  assign dp_output_data = acc;

  // Interface monitors
  int         hs_cnt    = 0;
  int         wr_w_cnt  = 0;
  int         seq_bad   = 0;
  int         nohs_bad  = 0;
  logic [5:0] w_seq     = 6'd0;

  always @(posedge clk) begin
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    if (dp_wr_en_w) begin
      if (dp_addr_w != w_seq) seq_bad <= seq_bad + 1;
      w_seq    <= w_seq + 6'd1;
      wr_w_cnt <= wr_w_cnt + 1;
    end
    if ((dp_wr_en_x || dp_wr_en_w) && !(in_valid && in_ready)) nohs_bad <= nohs_bad + 1;
  end

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic send_cmd(input logic skip);
    cmd_valid  = 1'b1;
    cmd_skip_w = skip;
    #1;
    check("cmd_ready idle", cmd_ready, 1);
    check("clear_acc on cmd", dp_clear_acc, 1);
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_skip_w = 1'b0;
    check("busy after cmd", busy, 1);
    check("cmd_ready after cmd", cmd_ready, 0);
    check("in_ready in load_x", in_ready, 1);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input bit gap);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("in_ready for word", in_ready, 1);
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      #1;
      check("no strobe in gap", {dp_wr_en_x, dp_wr_en_w}, 0);
      @(negedge clk);
    end
  endtask

  // Collect 8 row results. stall_row: hold out_ready low 5 cycles there.
  // abort_row: assert reset while that row's result is being offered.
  task automatic collect(input int exp_v[8], input int stall_row, input int abort_row);
    int t;
    for (int r = 0; r < 8; r++) begin
      t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("row%0d valid", r), out_valid, 1);
      check($sformatf("row%0d data", r), out_data, 64'(exp_v[r]));
      check($sformatf("row%0d last", r), out_last, (r == 7) ? 1 : 0);
      if (r == stall_row) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall valid", out_valid, 1);
          check("stall data", out_data, 64'(exp_v[r]));
          check("stall en_pipe", dp_en_pipe, 0);
          check("stall en_acc", dp_en_acc, 0);
        end
        out_ready = 1'b1;
      end
      if (r == abort_row) begin
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_last", out_last, 0);
        check("rst busy", busy, 0);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst in_ready", in_ready, 0);
        check("rst en_pipe", dp_en_pipe, 0);
        check("rst en_acc", dp_en_acc, 0);
        check("rst addr_w", dp_addr_w, 0);
        return;
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int exp_v[8];
  int hs0, ww0;

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_skip_w = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;

    repeat (2) @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset en_pipe", dp_en_pipe, 0);
    check("reset clear_acc", dp_clear_acc, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Test 1: X=[1..8], W=identity, in_valid gaps during W load.
    hs0 = hs_cnt; ww0 = wr_w_cnt;
    send_cmd(1'b1);  // no W resident yet: load is forced
    for (int i = 0; i < 8; i++) send_word(DATA_W'(i + 1), 1'b0);
    for (int k = 0; k < 64; k++) send_word(((k >> 3) == (k & 7)) ? 14'd1 : 14'd0, (k % 3) == 1);
    in_valid = 1'b0;
    check("t1 handshakes", hs_cnt - hs0, 72);
    check("t1 w writes", wr_w_cnt - ww0, 64);
    check("t1 w addr sequence", seq_bad, 0);
    check("t1 issue no valid", out_valid, 0);
    check("t1 issue en_pipe", dp_en_pipe, 1);
    @(negedge clk);
    check("t1 flush no valid", out_valid, 0);
    check("t1 flush en_pipe", dp_en_pipe, 1);
    @(negedge clk);
    check("t1 capture no valid", out_valid, 0);
    check("t1 capture en_acc", dp_en_acc, 1);
    @(negedge clk);
    check("t1 latency valid", out_valid, 1);
    for (int i = 0; i < 8; i++) exp_v[i] = i + 1;
    collect(exp_v, -1, -1);
    check("t1 idle cmd_ready", cmd_ready, 1);
    check("t1 idle busy", busy, 0);

    // Test 2: reuse W, X=[2]*8.
    hs0 = hs_cnt; ww0 = wr_w_cnt;
    send_cmd(1'b1);
    for (int i = 0; i < 8; i++) send_word(14'd2, 1'b0);
    in_valid = 1'b0;
    check("t2 no w load", in_ready, 0);
    check("t2 handshakes", hs_cnt - hs0, 8);
    for (int i = 0; i < 8; i++) exp_v[i] = 2;
    collect(exp_v, -1, -1);
    check("t2 w writes", wr_w_cnt - ww0, 0);

    // Test 3: reset while row 5 result is offered.
    send_cmd(1'b1);
    for (int i = 0; i < 8; i++) send_word(DATA_W'(i + 1), 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) exp_v[i] = i + 1;
    collect(exp_v, -1, 5);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Test 4: after reset skip is ignored; W all ones, X=[1..8], stall row 3.
    hs0 = hs_cnt; ww0 = wr_w_cnt;
    send_cmd(1'b1);
    for (int i = 0; i < 8; i++) send_word(DATA_W'(i + 1), 1'b0);
    check("t4 forced w load", in_ready, 1);
    for (int k = 0; k < 64; k++) send_word(14'd1, 1'b0);
    in_valid = 1'b0;
    check("t4 handshakes", hs_cnt - hs0, 72);
    check("t4 w writes", wr_w_cnt - ww0, 64);
    for (int i = 0; i < 8; i++) exp_v[i] = 36;
    collect(exp_v, 3, -1);
    check("t4 idle busy", busy, 0);
    check("strobes only on handshake", nohs_bad, 0);
    check("w addr sequence", seq_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
